i2c_master_ms: RTL

- Parametrised next-generation byte-level I2C master; drop-in successor for the existing command-driven master on the same CPU/bus-wrapper command interface.
- Adds:
  - configurable divider width;
  - configurable SCL/SDA input synchroniser depth;
  - slave clock-stretching support (SCL is bidirectional);
  - multi-master arbitration-loss detection with bus release.

---
 rtl/i2c_master_ms.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_ms.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_ms
// Purpose  : Byte-level, command-driven I2C master. It supports slave clock
//            stretching, multi-master arbitration-loss detection and a
//            configurable pad-input synchroniser depth.
// Ports    : clk, reset (async, active-high)
//            din[7:0]       write byte; din[0] is the ACK/NACK bit of a read
//            dvsr[DVSR_W-1:0] quarter SCL period minus 1 (clk cycles, >=1)
//            cmd[2:0]       0=START 1=WR 2=RD 3=STOP 4=RESTART (5..7 = WR)
//            wr_i2c         command strobe, taken only while ready=1
//            ready          block can accept a command
//            done_tick      one-cycle pulse at the end of each byte
//            ack            9th-bit value seen on the bus
//            dout[7:0]      received byte (bus readback on writes)
//            arb_lost       one-cycle pulse on arbitration loss
//            busy           high from START until STOP completes or loss
//            scl, sda       open-drain pads (drive 0 or Z)
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_ms #(
    parameter int DVSR_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        din,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic [2:0]        cmd,
    input  logic              wr_i2c,
    output logic              ready,
    output logic              done_tick,
    output logic              ack,
    output logic [7:0]        dout,
    output logic              arb_lost,
    output logic              busy,
    inout  wire               scl,
    inout  wire               sda
);

    localparam logic [2:0] c_cmd_start   = 3'd0;
    localparam logic [2:0] c_cmd_rd      = 3'd2;
    localparam logic [2:0] c_cmd_stop    = 3'd3;
    localparam logic [2:0] c_cmd_restart = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE, ST_START1, ST_START2, ST_HOLD,
        ST_DATA1, ST_DATA2, ST_DATA3, ST_DATA4, ST_DATA_END,
        ST_RESTART, ST_STOP1, ST_STOP2
    } state_t;

    state_t              r_state, w_state_next;
    logic [DVSR_W:0]     r_cnt, w_cnt_next;
    logic [8:0]          r_tx, w_tx_next;
    logic [8:0]          r_rx, w_rx_next;
    logic [3:0]          r_bit, w_bit_next;
    logic [2:0]          r_cmd, w_cmd_next;
    logic                r_scl_low, r_sda_low;
    logic                w_scl_out, w_sda_out;
    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                w_scl_in, w_sda_in;
    logic                w_qrtr_done, w_half_done;
    logic                w_read, w_data_release, w_timed, w_stretch;

    // Open-drain pads: only ever pull low, otherwise float.
    assign scl = r_scl_low ? 1'b0 : 1'bz;
    assign sda = r_sda_low ? 1'b0 : 1'bz;

    assign w_scl_in = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_in = r_sda_sync[SYNC_STAGES-1];

    // Quarter = dvsr+1 clocks, half = 2*(dvsr+1) clocks (terminal count 2*dvsr+1).
    assign w_qrtr_done = (r_cnt == {1'b0, dvsr});
    assign w_half_done = (r_cnt == {dvsr, 1'b1});

    assign w_read = (r_cmd == c_cmd_rd);
    // SDA floats for the slave's data bits on a read and for the slave's ACK on a write.
    assign w_data_release = w_read ? (r_bit != 4'd8) : (r_bit == 4'd8);

    assign w_timed   = (r_state != ST_IDLE) && (r_state != ST_HOLD);
    assign w_stretch = (r_state == ST_START1) || (r_state == ST_DATA2) ||
                       (r_state == ST_DATA3)  || (r_state == ST_RESTART) ||
                       (r_state == ST_STOP1)  || (r_state == ST_STOP2);

    assign busy = (r_state != ST_IDLE);
    assign dout = r_rx[8:1];
    assign ack  = r_rx[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_bit      <= '0;
            r_cmd      <= '0;
            r_scl_low  <= 1'b0;
            r_sda_low  <= 1'b0;
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_tx       <= w_tx_next;
            r_rx       <= w_rx_next;
            r_bit      <= w_bit_next;
            r_cmd      <= w_cmd_next;
            // On arbitration loss let go of both lines right away instead of
            // waiting for the IDLE decode to propagate.
            r_scl_low  <= !w_scl_out && !arb_lost;
            r_sda_low  <= !w_sda_out && !arb_lost;
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
        end
    end

    // Phase counter: cleared on every state change; in SCL-released states it
    // waits at zero until the bus actually shows SCL high (clock stretching).
    always_comb begin
        if ((w_state_next != r_state) || !w_timed) begin
            w_cnt_next = '0;
        end else if (w_stretch && (r_cnt == '0) && !w_scl_in) begin
            w_cnt_next = '0;
        end else begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx;
        w_rx_next    = r_rx;
        w_bit_next   = r_bit;
        w_cmd_next   = r_cmd;
        ready        = 1'b0;
        done_tick    = 1'b0;
        arb_lost     = 1'b0;
        w_scl_out    = 1'b1;
        w_sda_out    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (wr_i2c && (cmd == c_cmd_start)) begin
                    w_cmd_next   = cmd;
                    w_state_next = ST_START1;
                end
            end
            ST_START1: begin
                w_sda_out = 1'b0;
                if (w_half_done) w_state_next = ST_START2;
            end
            ST_START2: begin
                w_sda_out = 1'b0;
                w_scl_out = 1'b0;
                if (w_qrtr_done) w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                ready     = 1'b1;
                w_sda_out = 1'b0;
                w_scl_out = 1'b0;
                if (wr_i2c) begin
                    w_cmd_next = cmd;
                    if ((cmd == c_cmd_start) || (cmd == c_cmd_restart)) begin
                        w_state_next = ST_RESTART;
                    end else if (cmd == c_cmd_stop) begin
                        w_state_next = ST_STOP1;
                    end else begin
                        w_tx_next    = {din, din[0]};
                        w_bit_next   = '0;
                        w_state_next = ST_DATA1;
                    end
                end
            end
            ST_DATA1: begin
                w_scl_out = 1'b0;
                w_sda_out = r_tx[8] | w_data_release;
                if (w_qrtr_done) w_state_next = ST_DATA2;
            end
            ST_DATA2: begin
                w_sda_out = r_tx[8] | w_data_release;
                if (w_qrtr_done) begin
                    w_rx_next    = {r_rx[7:0], w_sda_in};
                    w_state_next = ST_DATA3;
                    // Only our own write data bits can lose arbitration.
                    if (!w_read && (r_bit != 4'd8) && r_tx[8] && !w_sda_in) begin
                        arb_lost     = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_DATA3: begin
                w_sda_out = r_tx[8] | w_data_release;
                if (w_qrtr_done) w_state_next = ST_DATA4;
            end
            ST_DATA4: begin
                w_scl_out = 1'b0;
                w_sda_out = r_tx[8] | w_data_release;
                if (w_qrtr_done) begin
                    if (r_bit == 4'd8) begin
                        done_tick    = 1'b1;
                        w_state_next = ST_DATA_END;
                    end else begin
                        w_tx_next    = {r_tx[7:0], 1'b0};
                        w_bit_next   = r_bit + 4'd1;
                        w_state_next = ST_DATA1;
                    end
                end
            end
            ST_DATA_END: begin
                w_sda_out = 1'b0;
                w_scl_out = 1'b0;
                if (w_qrtr_done) w_state_next = ST_HOLD;
            end
            ST_RESTART: begin
                if (w_half_done) w_state_next = ST_START1;
            end
            ST_STOP1: begin
                w_sda_out = 1'b0;
                if (w_half_done) w_state_next = ST_STOP2;
            end
            ST_STOP2: begin
                if (w_half_done) w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
